uart_row_loader: RTL

//  Consumes the byte stream from the UART receiver and parses framed row packets:

---
 rtl/uart_row_loader_if.sv | 23 ++
 rtl/uart_row_loader.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/uart_row_loader_if.sv
// Byte-stream input and frame-memory write port of the row loader.
interface uart_row_loader_if #(
    parameter int ADDR_W = 5
);
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              row_done;
    logic              row_err;
    logic              busy;

    modport master (
        output rx_byte, rx_valid,
        input  wr_en, wr_addr, wr_data, row_done, row_err, busy
    );

    modport slave (
        input  rx_byte, rx_valid,
        output wr_en, wr_addr, wr_data, row_done, row_err, busy
    );
endinterface

// File: rtl/uart_row_loader.sv
// Parses SYNC/ROW/data/CHK packets from the UART and writes checksum-good rows to frame memory.
// First write one cycle after the CHK strobe; no backpressure, bytes arriving during COMMIT are dropped.
module uart_row_loader #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         ROWS         = 8,
    parameter int         ROW_BYTES    = 4,
    parameter int         ADDR_W       = 5,
    parameter int         TIMEOUT_CLKS = 25_000
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    uart_row_loader_if.slave bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int IW = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(ROW_BYTES - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    ROWS_B   = 8'(ROWS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_DATA,
        S_CHK,
        S_COMMIT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    chk;
    logic [IW-1:0] idx;
    logic [RW-1:0] row;
    logic [TW-1:0] timer;
    logic [7:0]    row_buf [ROW_BYTES];
    logic          err_q;
    logic          err_nxt;
    logic          idx_last;
    logic          expired;
    logic          commit;

    assign idx_last = (idx == IDX_LAST);
    assign expired  = (timer == TMR_LAST);
    assign commit   = (state == S_COMMIT);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // A byte arriving in the expiry cycle wins over the timeout.
    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.rx_valid && bus.rx_byte == SYNC_BYTE) state_nxt = S_ROW;
            end
            S_ROW: begin
                if (bus.rx_valid) begin
                    if (bus.rx_byte >= ROWS_B) begin
                        state_nxt = S_IDLE;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end else if (expired) begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b1;
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    if (idx_last) state_nxt = S_CHK;
                end else if (expired) begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b1;
                end
            end
            S_CHK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_byte == chk) begin
                        state_nxt = S_COMMIT;
                    end else begin
                        state_nxt = S_IDLE;
                        err_nxt   = 1'b1;
                    end
                end else if (expired) begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b1;
                end
            end
            S_COMMIT: begin
                if (idx_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            chk   <= '0;
            idx   <= '0;
            row   <= '0;
            timer <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= err_nxt;
            unique case (state)
                S_IDLE: begin
                    chk   <= '0;
                    idx   <= '0;
                    timer <= '0;
                end
                S_ROW, S_DATA, S_CHK: begin
                    if (bus.rx_valid)  timer <= '0;
                    else if (!expired) timer <= timer + 1'b1;
                    if (bus.rx_valid && state == S_ROW) begin
                        row <= bus.rx_byte[RW-1:0];
                        chk <= bus.rx_byte;
                    end
                    if (bus.rx_valid && state == S_DATA) begin
                        chk <= chk ^ bus.rx_byte;
                        idx <= idx_last ? '0 : idx + 1'b1;
                    end
                end
                S_COMMIT: idx <= idx_last ? '0 : idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (state == S_DATA && bus.rx_valid) row_buf[idx] <= bus.rx_byte;
    end

    assign bus.wr_en    = commit;
    assign bus.wr_addr  = commit ? (ADDR_W'(row) * ADDR_W'(ROW_BYTES) + ADDR_W'(idx)) : '0;
    assign bus.wr_data  = commit ? row_buf[idx] : '0;
    assign bus.row_done = commit && idx_last;
    assign bus.row_err  = err_q;
    assign bus.busy     = (state != S_IDLE);
endmodule
